// File: rtl/lifo_buffer.sv
// lifo_buffer: single-clock last-in-first-out stack of 2**AWIDTH words.
// Registered pop data, fill count and empty/full status flags.
//
// Handshake: a push (wrreq_i) is accepted on a rising edge only when the
// stack is not full. A pop (rdreq_i) is accepted only when it is not empty.
// Both decisions use the fill count from before the edge. Requests that are
// not accepted are dropped silently; there is no stall or back-pressure.
// The popped word appears on q_o one cycle after the request.
module lifo_buffer #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wrreq_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] ONE_W   = (AWIDTH + 1)'(1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH:0]   usedw_q;
    logic [AWIDTH:0]   usedw_m1;
    logic [AWIDTH-1:0] top_addr;
    logic [AWIDTH-1:0] wr_addr;
    logic              rd_ok;
    logic              wr_ok;

    // Accept decisions and addressing, all derived from the pre-edge count.
    // A simultaneous push and pop overwrites the slot just popped, so the
    // new word becomes the top and the count is unchanged.
    always_comb begin
        rd_ok    = 1'b0;
        wr_ok    = 1'b0;
        usedw_m1 = usedw_q - ONE_W;
        top_addr = usedw_m1[AWIDTH-1:0];
        wr_addr  = usedw_q[AWIDTH-1:0];
        rd_ok    = rdreq_i && (usedw_q != '0);
        wr_ok    = wrreq_i && (usedw_q != DEPTH_W);
        if (rd_ok) begin
            wr_addr = top_addr;
        end
    end

    // Fill count: increments on push only, decrements on pop only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            usedw_q <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   usedw_q <= usedw_q + ONE_W;
                2'b01:   usedw_q <= usedw_q - ONE_W;
                default: usedw_q <= usedw_q;
            endcase
        end
    end

    // Read data register: loads the old top on an accepted pop, else holds.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= '0;
        end else if (rd_ok) begin
            q_o <= mem[top_addr];
        end
    end

    // Storage array: no reset, contents are irrelevant once the count is zero.
    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[wr_addr] <= data_i;
        end
    end

    // Status outputs track the count with no added latency.
    always_comb begin
        usedw_o = usedw_q;
        empty_o = (usedw_q == '0);
        full_o  = (usedw_q == DEPTH_W);
    end

endmodule

// File: tb/tb_lifo_buffer.sv
// tb_lifo_buffer: directed and randomized checks of lifo_buffer against a
// queue-based reference model of a stack.
module tb_lifo_buffer;

    localparam int DWIDTH = 8;
    localparam int AWIDTH = 4;
    localparam int DEPTH  = 2 ** AWIDTH;

    // ---------------- clock / reset ----------------
    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              wrreq_i = 1'b0;
    logic [DWIDTH-1:0] data_i = '0;
    logic              rdreq_i = 1'b0;
    logic [DWIDTH-1:0] q_o;
    logic              empty_o;
    logic              full_o;
    logic [AWIDTH:0]   usedw_o;

    always #5 clk_i = ~clk_i;

    lifo_buffer #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .wrreq_i (wrreq_i),
        .data_i  (data_i),
        .rdreq_i (rdreq_i),
        .q_o     (q_o),
        .empty_o (empty_o),
        .full_o  (full_o),
        .usedw_o (usedw_o)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [DWIDTH-1:0] exp_q[$];      // stack contents, back = top
    logic [DWIDTH-1:0] q_exp = '0;    // expected registered pop data
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},     32'(q_o),     32'(q_exp));
        check({tag, ".usedw"}, 32'(usedw_o), 32'(exp_q.size()));
        check({tag, ".empty"}, 32'(empty_o), 32'(exp_q.size() == 0));
        check({tag, ".full"},  32'(full_o),  32'(exp_q.size() == DEPTH));
    endtask

    // Stack semantics: pop sees the old top, then the push lands on top.
    task automatic model_step(input logic wr, input logic rd, input logic [DWIDTH-1:0] d);
        int n;
        n = exp_q.size();
        if (rd && n > 0) begin
            q_exp = exp_q[$];
            void'(exp_q.pop_back());
        end
        if (wr && n < DEPTH) begin
            exp_q.push_back(d);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic wr, input logic rd, input logic [DWIDTH-1:0] d, input string tag);
        @(negedge clk_i);
        wrreq_i = wr;
        rdreq_i = rd;
        data_i  = d;
        @(posedge clk_i);
        model_step(wr, rd, d);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk_i);
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        exp_q.delete();
        q_exp = '0;
        check_all({tag, ".async"});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            check_all({tag, ".hold"});
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2;
        check_all("por");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Reset then idle.
        async_reset("rst1");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'(i), "idle");

        // Fill past full, then drain past empty.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'($urandom), "fill");
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'($urandom), "drain");

        // Push+pop on empty: push accepted, q holds.
        step(1'b1, 1'b1, 8'h5C, "pp_empty");
        step(1'b0, 1'b1, 8'h00, "pp_empty_pop");

        // Simultaneous push/pop at usedw=5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), "pre5");
        step(1'b1, 1'b1, 8'hAA, "pp_mid");
        step(1'b0, 1'b1, 8'h00, "pp_mid_pop");
        check("pp_mid_aa", 32'(q_o), 32'h0000_00AA);

        // Push+pop on full: pop accepted, data discarded.
        while (exp_q.size() < DEPTH) step(1'b1, 1'b0, 8'($urandom), "refill");
        step(1'b1, 1'b1, 8'hEE, "pp_full");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, "drain2");

        // Random mix: push-heavy then balanced.
        for (int i = 0; i < 30; i++)
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30, 8'($urandom), "mix70");
        for (int i = 0; i < 20; i++)
            step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50, 8'($urandom), "mix50");

        // Reset mid-operation with data present and q loaded.
        while (exp_q.size() < 6) step(1'b1, 1'b0, 8'($urandom_range(1, 255)), "pre_rst");
        step(1'b0, 1'b1, 8'h00, "pre_rst_pop");
        async_reset("rst2");
        step(1'b0, 1'b1, 8'h00, "post_rst_pop");
        step(1'b1, 1'b0, 8'h3C, "post_rst_push");
        step(1'b0, 1'b1, 8'h00, "post_rst_pop2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
